// File: rtl/noc_pkg.sv
// Shared definitions for the PCI-to-NoC packetizer: flit field widths and
// offsets, and the frame FSM state encoding.
package noc_pkg;

  // Pixel byte width carried in the low bits of every flit.
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Field width for a count of 'value' items; never narrower than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int x_w(input int x_size);
    return clog2_min1(x_size);
  endfunction

  function automatic int y_w(input int y_size);
    return clog2_min1(y_size);
  endfunction

  function automatic int seq_w(input int image_size);
    return clog2_min1(image_size);
  endfunction

  // Flit layout, LSB first: data, x, y, seq.
  function automatic int x_off();
    return DATA_W;
  endfunction

  function automatic int y_off(input int x_size);
    return DATA_W + x_w(x_size);
  endfunction

  function automatic int seq_off(input int x_size, input int y_size);
    return DATA_W + x_w(x_size) + y_w(y_size);
  endfunction

  function automatic int flit_w(input int x_size, input int y_size, input int image_size);
    return DATA_W + x_w(x_size) + y_w(y_size) + seq_w(image_size);
  endfunction

endpackage

// File: rtl/pci_packetizer_if.sv
// Bundle of the PCI byte-stream input, the NoC flit output and the frame
// control/status lines. The packetizer sits on the slave side.
interface pci_packetizer_if
  import noc_pkg::*;
#(
  parameter int FLIT_W = flit_w(2, 2, 262144)
);
  logic              i_start;
  logic              i_valid_pci;
  logic [7:0]        i_data_pci;
  logic              o_ready_pci;
  logic              o_valid_noc;
  logic [FLIT_W-1:0] o_data_noc;
  logic              i_ready_noc;
  logic              o_done;

  modport master (
    output i_start, i_valid_pci, i_data_pci, i_ready_noc,
    input  o_ready_pci, o_valid_noc, o_data_noc, o_done
  );

  modport slave (
    input  i_start, i_valid_pci, i_data_pci, i_ready_noc,
    output o_ready_pci, o_valid_noc, o_data_noc, o_done
  );
endinterface

// File: rtl/flit_fifo2.sv
// Two-entry flit buffer. Head data is read straight from storage so a flit
// written at an edge is visible right after that edge.
module flit_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == 2'd2);
  assign empty  = (count_r == 2'd0);
  assign count  = count_r;
  assign dout   = mem_r[rd_ptr_r];
  // Overflowing or underflowing requests are dropped here as a last guard.
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Storage, pointers and occupancy; simultaneous push/pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pci_packetizer.sv
// Turns a frame of PCI pixel bytes into NoC flits tagged with a sequence
// number and a mesh destination that walks x first, then y.
module pci_packetizer
  import noc_pkg::*;
#(
  parameter int X_SIZE     = 2,
  parameter int Y_SIZE     = 2,
  parameter int IMAGE_SIZE = 262144
) (
  input  logic              clk,
  input  logic              rst,
  pci_packetizer_if.slave   bus
);

  localparam int X_W    = x_w(X_SIZE);
  localparam int Y_W    = y_w(Y_SIZE);
  localparam int SEQ_W  = seq_w(IMAGE_SIZE);
  localparam int FLIT_W = flit_w(X_SIZE, Y_SIZE, IMAGE_SIZE);
  localparam int X_OFF  = x_off();
  localparam int Y_OFF  = y_off(X_SIZE);
  localparam int S_OFF  = seq_off(X_SIZE, Y_SIZE);

  localparam logic [X_W-1:0]   X_LAST   = X_W'(X_SIZE - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(Y_SIZE - 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(IMAGE_SIZE - 1);

  state_e             state_r;
  state_e             state_s;
  logic [SEQ_W-1:0]   seq_r;
  logic [X_W-1:0]     x_r;
  logic [Y_W-1:0]     y_r;
  logic               ready_r;
  logic               done_r;

  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic               last_s;
  logic               enter_run_s;
  logic [1:0]         count_next_s;
  logic [FLIT_W-1:0]  flit_s;

  logic [FLIT_W-1:0]  fifo_dout_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [1:0]         fifo_count_s;

  assign accept_s    = bus.i_valid_pci && ready_r;
  assign push_s      = accept_s && !fifo_full_s;
  assign pop_s       = !fifo_empty_s && bus.i_ready_noc;
  assign last_s      = accept_s && (seq_r == SEQ_LAST);
  assign enter_run_s = bus.i_start && ((state_r == IDLE) || (state_r == DONE));

  // Assemble the flit for the byte currently on the PCI side.
  always_comb begin
    flit_s                    = '0;
    flit_s[DATA_W-1:0]        = bus.i_data_pci;
    flit_s[X_OFF +: X_W]      = x_r;
    flit_s[Y_OFF +: Y_W]      = y_r;
    flit_s[S_OFF +: SEQ_W]    = seq_r;
  end

  flit_fifo2 #(
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (flit_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Buffer occupancy after this edge, used to register o_ready_pci ahead.
  always_comb begin
    count_next_s = fifo_count_s;
    case ({push_s, pop_s})
      2'b10:   count_next_s = fifo_count_s + 2'd1;
      2'b01:   count_next_s = fifo_count_s - 2'd1;
      default: count_next_s = fifo_count_s;
    endcase
  end

  // Frame FSM next state; start requests only count in IDLE and DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.i_start) state_s = RUN;
        else             state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DRAIN;
        else        state_s = RUN;
      end
      DRAIN: begin
        if (fifo_empty_s) state_s = DONE;
        else              state_s = DRAIN;
      end
      DONE: begin
        if (bus.i_start) state_s = RUN;
        else             state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Sequence and destination counters, restarted on every frame start.
  always_ff @(posedge clk) begin
    if (rst || enter_run_s) begin
      seq_r <= '0;
      x_r   <= '0;
      y_r   <= '0;
    end else if (push_s) begin
      seq_r <= seq_r + SEQ_W'(1);
      if (x_r == X_LAST) begin
        x_r <= '0;
        if (y_r == Y_LAST) y_r <= '0;
        else               y_r <= y_r + Y_W'(1);
      end else begin
        x_r <= x_r + X_W'(1);
        y_r <= y_r;
      end
    end else begin
      seq_r <= seq_r;
      x_r   <= x_r;
      y_r   <= y_r;
    end
  end

  // Status outputs registered from the upcoming state and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_s == RUN) && (count_next_s < 2'd2);
      done_r  <= (state_s == DONE);
    end
  end

  assign bus.o_ready_pci = ready_r;
  assign bus.o_valid_noc = !fifo_empty_s;
  assign bus.o_data_noc  = fifo_dout_s;
  assign bus.o_done      = done_r;

endmodule

// File: tb/tb_pci_packetizer.sv
// Directed bench for pci_packetizer with a 2x2 mesh and 8-byte frames.
module tb_pci_packetizer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   rand_mode;
  logic [12:0] got_q [$];

  bit exp_x [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  bit exp_y [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  pci_packetizer_if #(.FLIT_W(13)) bus ();

  pci_packetizer #(
    .X_SIZE     (2),
    .Y_SIZE     (2),
    .IMAGE_SIZE (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every flit that will pop at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && bus.o_valid_noc && bus.i_ready_noc) got_q.push_back(bus.o_data_noc);
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] mk_flit(input int seq, input logic [7:0] d);
    logic [2:0] s;
    s = seq[2:0];
    return {s, exp_y[seq], exp_x[seq], d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) bus.i_ready_noc = 1'($urandom_range(0, 1));
  endtask

  task automatic start_frame();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit can;
    int n;
    bus.i_valid_pci = 1'b1;
    bus.i_data_pci  = d;
    n = 0;
    do begin
      can = bus.o_ready_pci;
      tick();
      n++;
    end while (!can && n < 60);
    check_eq("send_accept", 32'(can), 32'd1);
    bus.i_valid_pci = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.o_done && n < 300) begin
      tick();
      n++;
    end
    check_eq("done_reached", 32'(bus.o_done), 32'd1);
  endtask

  task automatic check_frame(input logic [7:0] base);
    check_eq("frame_len", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check_eq($sformatf("flit%0d", i), 32'(got_q[i]), 32'(mk_flit(i, base + 8'(i))));
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rand_mode       = 1'b0;
    rst             = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_valid_pci = 1'b0;
    bus.i_data_pci  = 8'h00;
    bus.i_ready_noc = 1'b0;

    // Reset, then idle without a start request.
    repeat (3) tick();
    check_eq("rst_ready", 32'(bus.o_ready_pci), 32'd0);
    check_eq("rst_valid", 32'(bus.o_valid_noc), 32'd0);
    check_eq("rst_done",  32'(bus.o_done), 32'd0);
    check_eq("rst_data",  32'(bus.o_data_noc), 32'd0);
    rst = 1'b0;
    repeat (10) begin
      tick();
      check_eq("idle_ready", 32'(bus.o_ready_pci), 32'd0);
      check_eq("idle_valid", 32'(bus.o_valid_noc), 32'd0);
    end

    // Full frame streamed with the NoC always ready.
    got_q.delete();
    bus.i_ready_noc = 1'b1;
    start_frame();
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h10 + 8'(i));
      if (i == 0) begin
        check_eq("first_valid", 32'(bus.o_valid_noc), 32'd1);
        check_eq("first_data", 32'(bus.o_data_noc), 32'(mk_flit(0, 8'h10)));
      end
    end
    check_eq("last_ready", 32'(bus.o_ready_pci), 32'd0);
    check_eq("drain_done0", 32'(bus.o_done), 32'd0);
    tick();
    check_eq("drain_done1", 32'(bus.o_done), 32'd0);
    check_eq("drain_valid", 32'(bus.o_valid_noc), 32'd0);
    tick();
    check_eq("done_rise", 32'(bus.o_done), 32'd1);
    check_frame(8'h10);

    // Backpressure: two accepts fill the buffer, head holds still.
    got_q.delete();
    bus.i_ready_noc = 1'b0;
    start_frame();
    send_byte(8'h10);
    send_byte(8'h11);
    check_eq("bp_ready", 32'(bus.o_ready_pci), 32'd0);
    check_eq("bp_valid", 32'(bus.o_valid_noc), 32'd1);
    check_eq("bp_head", 32'(bus.o_data_noc), 32'(mk_flit(0, 8'h10)));
    repeat (3) tick();
    check_eq("bp_hold", 32'(bus.o_data_noc), 32'(mk_flit(0, 8'h10)));
    check_eq("bp_ready_hold", 32'(bus.o_ready_pci), 32'd0);
    bus.i_ready_noc = 1'b1;
    for (int i = 2; i < 8; i++) send_byte(8'h10 + 8'(i));
    wait_done();
    check_frame(8'h10);

    // Random NoC readiness and random byte gaps.
    got_q.delete();
    rand_mode = 1'b1;
    start_frame();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(8'h20 + 8'(i));
    end
    wait_done();
    rand_mode = 1'b0;
    bus.i_ready_noc = 1'b1;
    check_frame(8'h20);

    // Reset mid-frame with two flits buffered.
    got_q.delete();
    bus.i_ready_noc = 1'b1;
    start_frame();
    send_byte(8'h30);
    send_byte(8'h31);
    send_byte(8'h32);
    tick();
    bus.i_ready_noc = 1'b0;
    send_byte(8'h33);
    send_byte(8'h34);
    check_eq("mid_ready", 32'(bus.o_ready_pci), 32'd0);
    check_eq("mid_head", 32'(bus.o_data_noc), 32'(mk_flit(3, 8'h33)));
    check_eq("mid_popped", 32'(got_q.size()), 32'd3);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_valid", 32'(bus.o_valid_noc), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.o_ready_pci), 32'd0);
    check_eq("mid_rst_data", 32'(bus.o_data_noc), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      tick();
      check_eq("mid_idle_ready", 32'(bus.o_ready_pci), 32'd0);
      check_eq("mid_idle_valid", 32'(bus.o_valid_noc), 32'd0);
    end
    got_q.delete();
    bus.i_ready_noc = 1'b1;
    start_frame();
    send_byte(8'h40);
    check_eq("restart_valid", 32'(bus.o_valid_noc), 32'd1);
    check_eq("restart_data", 32'(bus.o_data_noc), 32'(mk_flit(0, 8'h40)));
    for (int i = 1; i < 8; i++) send_byte(8'h40 + 8'(i));
    wait_done();
    check_frame(8'h40);

    // Bytes offered in DONE without a start are ignored.
    got_q.delete();
    bus.i_valid_pci = 1'b1;
    bus.i_data_pci  = 8'h55;
    repeat (5) begin
      tick();
      check_eq("done_ign_valid", 32'(bus.o_valid_noc), 32'd0);
      check_eq("done_ign_ready", 32'(bus.o_ready_pci), 32'd0);
    end
    bus.i_valid_pci = 1'b0;
    check_eq("done_ign_count", 32'(got_q.size()), 32'd0);
    start_frame();
    send_byte(8'h60);
    check_eq("new_valid", 32'(bus.o_valid_noc), 32'd1);
    check_eq("new_data", 32'(bus.o_data_noc), 32'(mk_flit(0, 8'h60)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pci_packetizer.md
PCI_PACKETIZER -- requirements
Module: pci_packetizer

Interface
REQ-001 Parameter X_SIZE, default 2: mesh columns; destination x field width X_W = clog2(X_SIZE), minimum 1.
REQ-002 Parameter Y_SIZE, default 2: mesh rows; destination y field width Y_W = clog2(Y_SIZE), minimum 1.
REQ-003 Parameter IMAGE_SIZE, default 262144: bytes per frame; sequence field width SEQ_W = clog2(IMAGE_SIZE).
REQ-004 Port clk  in  1  sole clock; every register updates on its rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port i_start  in  1  single-cycle frame start request.
REQ-007 Port i_valid_pci  in  1  PCI byte valid.
REQ-008 Port i_data_pci  in  8  PCI pixel byte.
REQ-009 Port o_ready_pci  out  1  block can accept a byte this cycle.
REQ-010 Port o_valid_noc  out  1  flit valid toward the NoC local port.
REQ-011 Port o_data_noc  out  8+X_W+Y_W+SEQ_W  flit {seq, y, x, data}, with data in the LSBs.
REQ-012 Port i_ready_noc  in  1  NoC accepts the flit.
REQ-013 Port o_done  out  1  frame fully handed to the NoC.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE->RUN on i_start; DONE->RUN on i_start; i_start is ignored in RUN and DRAIN.
REQ-016 Entering RUN clears the sequence counter and destination to (x=0, y=0).
REQ-017 A byte is accepted when i_valid_pci && o_ready_pci.
REQ-018 o_ready_pci = (state==RUN) && buffer count < 2; it is driven from registers only.
REQ-019 Each accepted byte forms one flit: data = byte, x/y = current destination, seq = current counter value.
REQ-020 After each accept: seq increments; x increments, wrapping to 0 at X_SIZE with y incremented; y wraps to 0 at Y_SIZE.
REQ-021 Accepted flits enter a 2-entry FIFO; o_valid_noc = FIFO non-empty; o_data_noc = FIFO head.
REQ-022 Latency: a byte accepted at edge N is visible on o_data_noc after edge N, with no extra cycle.
REQ-023 A flit pops on o_valid_noc && i_ready_noc.
REQ-024 With push and pop in the same cycle, count is unchanged and order is preserved.
REQ-025 o_data_noc holds stable while o_valid_noc && !i_ready_noc.
REQ-026 The accept of seq = IMAGE_SIZE-1 moves RUN->DRAIN; o_ready_pci is 0 from the next cycle.
REQ-027 DRAIN->DONE when the FIFO is empty.
REQ-028 o_done = 1 only in DONE.
REQ-029 i_valid_pci while o_ready_pci=0 is ignored: no accept, no counter change.
REQ-030 No flit is ever dropped or duplicated.

Reset
REQ-031 When rst=1 at an edge: state=IDLE, FIFO emptied, seq=0, x=0, y=0.
REQ-032 When rst=1 at an edge, outputs are zero: o_ready_pci=0, o_valid_noc=0, o_done=0, o_data_noc=0.
REQ-033 Reset mid-frame discards buffered flits; the block requires i_start afterwards.

Structure
REQ-034 noc_pkg holds the flit field widths/offsets helper functions and the FSM state enum.
REQ-035 The 2-entry buffer is sub-module flit_fifo2, parameterised by width.
REQ-036 flit_fifo2 has push/pop/full/empty; its count is a 2-bit register.
REQ-037 Counters and the FSM reside in pci_packetizer.

Verification (X_SIZE=2, Y_SIZE=2, IMAGE_SIZE=8)
REQ-038 Scenario: rst high 3 cycles, then low, no i_start -> o_ready_pci=0 and o_valid_noc=0 indefinitely.
REQ-039 Scenario: i_start, bytes 0x10..0x17 streamed, i_ready_noc=1 -> flits in order.
- Expected (x,y,seq): (0,0,0) (1,0,1) (0,1,2) (1,1,3) (0,0,4) (1,0,5) (0,1,6) (1,1,7).
- o_done rises the cycle after the last pop.
REQ-040 Scenario: i_ready_noc=0 after 2 accepts -> o_ready_pci=0; o_data_noc holds 0x10 flit.
- After i_ready_noc=1: no loss, 0x12 next.
REQ-041 Scenario: random i_ready_noc 50% with random i_valid_pci -> output seq strictly 0..7 with matching data.
REQ-042 Scenario: rst asserted after 5 accepts with FIFO holding 2 -> next cycle o_valid_noc=0, state IDLE.
- New i_start restarts at seq=0, dest (0,0).
REQ-043 Scenario: in DONE, i_valid_pci=1 without i_start -> no flit produced.
- i_start -> new frame with seq=0.
